// File: rtl/debug_data_sender_pkg.sv
// rtl/debug_data_sender_pkg.sv - shared state, section and framing constants for the debug data sender
package debug_data_sender_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
        S_DONE
    } send_state_t;

    typedef enum logic [1:0] {
        SEC_CLK,
        SEC_PC,
        SEC_REGS,
        SEC_MEM
    } section_t;

    typedef enum logic [1:0] {
        PH_HEADER,
        PH_DATA,
        PH_TRAILER
    } frame_phase_t;

    localparam logic [7:0] DEBUG_HEADER_BYTE     = 8'hA5;
    localparam int         DEFAULT_NUM_REGS      = 32;
    localparam int         DEFAULT_NUM_MEM_WORDS = 16;

    // One spare bit so a counter can reach its bound without wrapping.
    function automatic int cnt_bits(input int bound);
        return $clog2(bound) + 1;
    endfunction

endpackage

// File: rtl/debug_data_sender_word_byte_serializer.sv
// rtl/debug_data_sender_word_byte_serializer.sv - splits a word into LSB-first bytes, qualifies tx_done, flags the last byte
module word_byte_serializer
    import debug_data_sender_pkg::*;
#(
    parameter int PROC_BITS = 32,
    parameter int UART_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [PROC_BITS-1:0] word,
    input  logic                 waiting,
    input  logic                 tx_done,
    output logic [UART_BITS-1:0] byte_data,
    output logic                 byte_accepted,
    output logic                 last_byte
);

    localparam int NUM_BYTES = PROC_BITS / UART_BITS;
    localparam int BCW       = cnt_bits(NUM_BYTES);

    logic [PROC_BITS-1:0] shift_q;
    logic [BCW-1:0]       byte_cnt;

    assign byte_data     = shift_q[UART_BITS-1:0];
    assign byte_accepted = waiting && tx_done;
    assign last_byte     = (byte_cnt == BCW'(NUM_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shift_q  <= word;
            byte_cnt <= '0;
        end else if (byte_accepted && !last_byte) begin
            shift_q  <= shift_q >> UART_BITS;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debug_data_sender.sv
// rtl/debug_data_sender.sv - dumps cycle count, PC, registers and data memory to the UART
// DEBUG_SEND_FRAMING_EN adds an A5 header byte and an XOR checksum trailer byte.
module debug_data_sender
    import debug_data_sender_pkg::*;
#(
    parameter int UART_BITS        = 8,
    parameter int PROC_BITS        = 32,
    parameter int PC_BITS          = 32,
    parameter int CLK_COUNTER_BITS = 32,
    parameter int REG_ADDRS_BITS   = 5,
    parameter int DATA_ADDRS_BITS  = 5,
    parameter int NUM_REGS         = DEFAULT_NUM_REGS,
    parameter int NUM_MEM_WORDS    = DEFAULT_NUM_MEM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_send_start,
    input  logic [CLK_COUNTER_BITS-1:0] i_clk_count,
    input  logic [PC_BITS-1:0]          i_pc,
    output logic [REG_ADDRS_BITS-1:0]   o_reg_addr,
    input  logic [PROC_BITS-1:0]        i_reg_data,
    output logic [DATA_ADDRS_BITS-1:0]  o_mem_addr,
    input  logic [PROC_BITS-1:0]        i_mem_data,
    output logic [UART_BITS-1:0]        o_tx_data,
    output logic                        o_tx_start,
    input  logic                        i_tx_done,
    output logic                        o_send_done,
    output logic                        o_busy
);

    localparam int WCW = cnt_bits(NUM_REGS > NUM_MEM_WORDS ? NUM_REGS : NUM_MEM_WORDS);

    send_state_t                 state;
    section_t                    sec;
    section_t                    nxt_sec;
    logic [WCW-1:0]              word_cnt;
    logic [WCW-1:0]              nxt_word;
    logic                        last_word;
    logic                        last_section;
    logic [CLK_COUNTER_BITS-1:0] clk_snap;
    logic [PC_BITS-1:0]          pc_snap;
    logic [PROC_BITS-1:0]        load_word;
    logic [UART_BITS-1:0]        ser_byte;
    logic                        byte_accepted;
    logic                        last_byte;

    assign o_busy = (state != S_IDLE);

    always_comb begin
        last_word    = 1'b1;
        last_section = 1'b0;
        case (sec)
            SEC_REGS: begin
                last_word    = (word_cnt == WCW'(NUM_REGS - 1));
                last_section = (NUM_MEM_WORDS == 0);
            end
            SEC_MEM: begin
                last_word    = (word_cnt == WCW'(NUM_MEM_WORDS - 1));
                last_section = 1'b1;
            end
            default: ;
        endcase
        nxt_sec  = sec;
        nxt_word = word_cnt + 1'b1;
        if (last_word) begin
            nxt_sec  = section_t'(sec + 2'd1);
            nxt_word = '0;
        end
    end

    always_comb begin
        case (sec)
            SEC_CLK:  load_word = PROC_BITS'(clk_snap);
            SEC_PC:   load_word = PROC_BITS'(pc_snap);
            SEC_REGS: load_word = i_reg_data;
            default:  load_word = i_mem_data;
        endcase
    end

    word_byte_serializer #(
        .PROC_BITS (PROC_BITS),
        .UART_BITS (UART_BITS)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .load          (state == S_LATCH),
        .word          (load_word),
        .waiting       (state == S_WAIT_TX),
        .tx_done       (i_tx_done),
        .byte_data     (ser_byte),
        .byte_accepted (byte_accepted),
        .last_byte     (last_byte)
    );

`ifdef DEBUG_SEND_FRAMING_EN
    frame_phase_t         phase;
    logic [UART_BITS-1:0] csum;

    assign o_tx_data = (phase == PH_DATA)   ? ser_byte :
                       (phase == PH_HEADER) ? UART_BITS'(DEBUG_HEADER_BYTE) : csum;
`else
    assign o_tx_data = ser_byte;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sec         <= SEC_CLK;
            word_cnt    <= '0;
            clk_snap    <= '0;
            pc_snap     <= '0;
            o_reg_addr  <= '0;
            o_mem_addr  <= '0;
            o_tx_start  <= 1'b0;
            o_send_done <= 1'b0;
`ifdef DEBUG_SEND_FRAMING_EN
            phase       <= PH_DATA;
            csum        <= '0;
`endif
        end else begin
            o_tx_start  <= 1'b0;
            o_send_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_send_start) begin
                        clk_snap <= i_clk_count;
                        pc_snap  <= i_pc;
                        sec      <= SEC_CLK;
                        word_cnt <= '0;
`ifdef DEBUG_SEND_FRAMING_EN
                        phase      <= PH_HEADER;
                        csum       <= '0;
                        o_tx_start <= 1'b1;
                        state      <= S_SEND;
`else
                        state    <= S_LOAD;
`endif
                    end
                end
                S_LOAD:  state <= S_LATCH;
                S_LATCH: begin
                    o_tx_start <= 1'b1;
                    state      <= S_SEND;
                end
                S_SEND:  state <= S_WAIT_TX;
                S_WAIT_TX: begin
                    if (byte_accepted) begin
`ifdef DEBUG_SEND_FRAMING_EN
                        if (phase == PH_DATA)
                            csum <= csum ^ ser_byte;
                        if (phase == PH_HEADER) begin
                            phase <= PH_DATA;
                            state <= S_LOAD;
                        end else if (phase == PH_TRAILER) begin
                            o_send_done <= 1'b1;
                            state       <= S_DONE;
                        end else
`endif
                        if (!last_byte) begin
                            o_tx_start <= 1'b1;
                            state      <= S_SEND;
                        end else if (!(last_word && last_section)) begin
                            sec      <= nxt_sec;
                            word_cnt <= nxt_word;
                            // Address must be valid during LOAD so data is ready in LATCH.
                            if (nxt_sec == SEC_REGS)
                                o_reg_addr <= REG_ADDRS_BITS'(nxt_word);
                            if (nxt_sec == SEC_MEM)
                                o_mem_addr <= DATA_ADDRS_BITS'(nxt_word);
                            state <= S_LOAD;
                        end else begin
`ifdef DEBUG_SEND_FRAMING_EN
                            phase      <= PH_TRAILER;
                            o_tx_start <= 1'b1;
                            state      <= S_SEND;
`else
                            o_send_done <= 1'b1;
                            state       <= S_DONE;
`endif
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_data_sender.md
Name: debug_data_sender

Overview:
- Transmit side of the debug unit's run/report handshake.
- When the run controller pulses send-start after a halt, this block snapshots the cycle count and PC. It then walks the register file and the first data-memory words through their debug read ports.
- Every word is serialised LSB-byte-first to the UART transmitter. When the last byte has been accepted, the block pulses send-done back to the run controller.

Parameters:
- UART_BITS, 8, UART byte width.
- PROC_BITS, 32, word width; must be a multiple of UART_BITS.
- PC_BITS, 32, program counter width; zero-extended to PROC_BITS.
- CLK_COUNTER_BITS, 32, cycle-count width; zero-extended to PROC_BITS.
- REG_ADDRS_BITS, 5, register-file debug address width.
- DATA_ADDRS_BITS, 5, data-memory debug address width.
- NUM_REGS, 32, registers dumped (≤ 2^REG_ADDRS_BITS).
- NUM_MEM_WORDS, 16, data-memory words dumped starting at address 0 (≤ 2^DATA_ADDRS_BITS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_send_start  in  1  start pulse from the run controller.
- i_clk_count  in  CLK_COUNTER_BITS  cycle count; sampled on accepted start.
- i_pc  in  PC_BITS  PC; sampled on accepted start.
- o_reg_addr  out  REG_ADDRS_BITS  register-file debug read address.
- i_reg_data  in  PROC_BITS  register data, valid 1 cycle after address.
- o_mem_addr  out  DATA_ADDRS_BITS  data-memory debug read address.
- i_mem_data  in  PROC_BITS  memory data, valid 1 cycle after address.
- o_tx_data  out  UART_BITS  byte to the UART transmitter.
- o_tx_start  out  1  one-cycle transmit request.
- i_tx_done  in  1  one-cycle pulse when the transmitter finishes a byte.
- o_send_done  out  1  one-cycle completion pulse.
- o_busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset asserted mid-operation: return to IDLE immediately and drop o_tx_start. No done pulse is produced.
- Word order:
  - clk_count.
  - PC.
  - regs 0..NUM_REGS-1.
  - mem 0..NUM_MEM_WORDS-1.
- Each word is sent as PROC_BITS/UART_BITS bytes, LSB first.
- Defaults give 200 bytes.
- State machine:
  - IDLE: on i_send_start, latch i_clk_count and i_pc, clear section, word and byte counters, go to LOAD. Otherwise stay in IDLE.
  - LOAD: drive o_reg_addr or o_mem_addr with the word index; go to LATCH. For the CLK and PC sections no read is needed, but the path is kept uniform.
  - LATCH: load the shift register from the snapshot, i_reg_data or i_mem_data; clear the byte counter; go to SEND.
  - SEND: o_tx_start=1 for exactly 1 cycle, with o_tx_data = shift[UART_BITS-1:0]; go to WAIT_TX.
  - WAIT_TX: hold o_tx_data. On i_tx_done:
    - If this is not the last byte of the word: shift right by UART_BITS, increment the byte counter, go to SEND.
    - Else if this is not the last word of the last section: advance the word counter, or move to the next section with the word counter reset to 0; go to LOAD.
    - Else go to DONE.
  - DONE: o_send_done=1 for 1 cycle; go to IDLE.
- o_reg_addr and o_mem_addr hold their last value outside LOAD/LATCH.
- i_send_start while busy is ignored; no restart and no re-latch.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_done arriving in the same cycle as o_tx_start is ignored, because it is sampled only in WAIT_TX.
- NUM_MEM_WORDS=0: the MEM section is skipped; DONE follows the last register byte.
- Counter widths: clog2 of each bound + 1, so they never wrap before the compare.
- Minimum latency from start to the first o_tx_start: 3 cycles (LOAD, LATCH, SEND).

Optional Feature:
- Macro: DEBUG_SEND_FRAMING_EN.
- Defined:
  - Before the first data byte, send header byte 8'hA5 via SEND/WAIT_TX.
  - After the last data byte, send a trailer byte equal to the XOR of all data bytes; then go to DONE.
  - Total bytes with defaults: 202.
- Undefined: raw data stream only; no header/trailer states or checksum register are synthesised.

Decomposition:
- Shared constants file (alongside the existing debug constants):
  - state encodings;
  - section codes CLK/PC/REGS/MEM;
  - DEBUG_HEADER_BYTE = 8'hA5;
  - default NUM_REGS and NUM_MEM_WORDS.
- One natural sub-module, word_byte_serializer:
  - loads a PROC_BITS word;
  - drives the tx_start/tx_done handshake per byte;
  - flags the last byte.
- The top level owns sectioning, read ports and done generation.

Test Plan:
- Basic dump, transmitter model returning i_tx_done 10 cycles after each o_tx_start:
  - stimulus: start with clk_count=0x0000002A, pc=0x00000040, reg[k]=0x11110000+k, mem[k]=0xCAFE0000+k;
  - response: bytes 2A 00 00 00 40 00 00 00 00 00 11 11 ..., ending 0F 00 FE CA; exactly 200 o_tx_start pulses; one o_send_done.
- Start while busy: second i_send_start at byte 5 with pc=0xFFFF -> ignored; the stream is unchanged and the PC bytes remain 40 00 00 00.
- Reset mid-word: assert rst during WAIT_TX of byte 70 -> o_busy=0 and o_tx_start=0 in the same cycle; no o_send_done; a fresh start re-sends from byte 2A.
- Spurious i_tx_done: pulses in IDLE and in the SEND cycle -> no byte advance; total count still 200.
- NUM_MEM_WORDS=0 build -> 136 bytes; o_send_done 1 cycle after the final WAIT_TX completion.
- With DEBUG_SEND_FRAMING_EN, all regs/mem/count/pc = 0 -> stream A5, 200×00, 00; 202 bytes total.
